// File: rtl/npc_mc.sv
// rtl/npc_mc.sv - multi-cycle NPC core: fetch FSM, register file, decode and ALU (optional NPC_FETCH_TIMEOUT_EN watchdog)
module npc_mc #(
    parameter int              XLEN           = 32,
    parameter int              NR_REGS        = 32,
    parameter logic [XLEN-1:0] RESET_PC       = 32'h8000_0000,
    parameter int              TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst,
    output logic            retire,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] wdata,
    output logic            halt,
    output logic [1:0]      halt_cause,
    output logic [XLEN-1:0] a0
);

    localparam int RW = $clog2(NR_REGS);

    if (XLEN != 32) begin : g_bad_xlen
        $error("npc_mc supports only XLEN = 32");
    end
    if (NR_REGS != 32 && NR_REGS != 16) begin : g_bad_nregs
        $error("npc_mc supports NR_REGS of 16 or 32");
    end

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic [1:0]      cause_q;
    logic [XLEN-1:0] regs [NR_REGS];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_idx, rs1_idx, rs2_idx;
    logic [XLEN-1:0] rs1_v, rs2_v;
    logic [XLEN-1:0] imm_i, imm_u, imm_j;
    logic [XLEN-1:0] ex_val, ex_pc;
    logic            ex_wr, ex_ill, ex_brk, uses_rs1, uses_rs2;
    logic            tmo_hit;

    // Register indices above the implemented file (RV32E) make the instruction illegal.
    function automatic logic idx_ok(input logic [4:0] r);
        return int'(r) < NR_REGS;
    endfunction

    // Decode and execute the latched instruction; results are consumed only in EXEC.
    always_comb begin
        opcode   = inst_q[6:0];
        funct3   = inst_q[14:12];
        funct7   = inst_q[31:25];
        rd_idx   = inst_q[11:7];
        rs1_idx  = inst_q[19:15];
        rs2_idx  = inst_q[24:20];
        rs1_v    = regs[rs1_idx[RW-1:0]];
        rs2_v    = regs[rs2_idx[RW-1:0]];
        imm_i    = XLEN'($signed(inst_q[31:20]));
        imm_u    = {inst_q[31:12], 12'b0};
        imm_j    = XLEN'($signed({inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0}));
        ex_val   = '0;
        ex_pc    = pc_q + XLEN'(4);
        ex_wr    = 1'b0;
        ex_ill   = 1'b0;
        ex_brk   = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            7'b0010011: begin
                uses_rs1 = 1'b1;
                ex_wr    = 1'b1;
                if (funct3 == 3'b000)
                    ex_val = rs1_v + imm_i;
                else if (funct3 == 3'b010)
                    ex_val = ($signed(rs1_v) < $signed(imm_i)) ? XLEN'(1) : '0;
                else
                    ex_ill = 1'b1;
            end
            7'b0110011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                ex_wr    = 1'b1;
                if (funct3 == 3'b000 && funct7 == 7'b0000000)
                    ex_val = rs1_v + rs2_v;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000)
                    ex_val = rs1_v - rs2_v;
                else
                    ex_ill = 1'b1;
            end
            7'b0110111: begin
                ex_wr  = 1'b1;
                ex_val = imm_u;
            end
            7'b0010111: begin
                ex_wr  = 1'b1;
                ex_val = pc_q + imm_u;
            end
            7'b1101111: begin
                ex_wr  = 1'b1;
                ex_val = pc_q + XLEN'(4);
                ex_pc  = pc_q + imm_j;
            end
            7'b1100111: begin
                uses_rs1 = 1'b1;
                ex_wr    = 1'b1;
                ex_val   = pc_q + XLEN'(4);
                ex_pc    = (rs1_v + imm_i) & ~XLEN'(1);
                if (funct3 != 3'b000)
                    ex_ill = 1'b1;
            end
            7'b1110011: begin
                if (inst_q == 32'h0010_0073) begin
                    ex_brk = 1'b1;
                    ex_pc  = pc_q;
                end else begin
                    ex_ill = 1'b1;
                end
            end
            default: ex_ill = 1'b1;
        endcase
        if ((ex_wr && !idx_ok(rd_idx)) || (uses_rs1 && !idx_ok(rs1_idx)) ||
            (uses_rs2 && !idx_ok(rs2_idx)))
            ex_ill = 1'b1;
    end

`ifdef NPC_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Watchdog: restarts on every entry to FETCH, counts while fetching or waiting.
    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state_next == S_FETCH && state != S_FETCH)
            tmo_cnt <= '0;
        else if (state == S_FETCH || state == S_WAIT)
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state selection for the fetch/execute sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                if (tmo_hit)
                    state_next = S_HALT;
                else if (imem_req_ready)
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                if (tmo_hit)
                    state_next = S_HALT;
                else if (imem_rsp_valid)
                    state_next = S_EXEC;
            end
            S_EXEC:  state_next = (ex_brk || ex_ill) ? S_HALT : S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    // Architectural state: FSM, PC, latched instruction, halt cause and register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RESET;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            cause_q <= 2'd0;
            for (int i = 0; i < NR_REGS; i++)
                regs[i] <= '0;
        end else begin
            state <= state_next;
            if (state == S_WAIT && imem_rsp_valid && !tmo_hit)
                inst_q <= imem_rsp_data;
            if ((state == S_FETCH || state == S_WAIT) && state_next == S_HALT)
                cause_q <= 2'd2;
            if (state == S_EXEC) begin
                if (ex_ill) begin
                    cause_q <= 2'd1;
                end else begin
                    pc_q <= ex_pc;
                    if (ex_brk)
                        cause_q <= 2'd0;
                    if (ex_wr && rd_idx != 5'd0)
                        regs[rd_idx[RW-1:0]] <= ex_val;
                end
            end
        end
    end

    assign imem_req_valid = (state == S_FETCH);
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign inst           = inst_q;
    assign retire         = (state == S_EXEC) && !ex_ill;
    assign rd             = (retire && ex_wr) ? rd_idx : 5'd0;
    assign wdata          = retire ? ex_val : '0;
    assign halt           = (state == S_HALT);
    assign halt_cause     = cause_q;
    assign a0             = regs[10];

endmodule

// File: tb/tb_npc_mc.sv
// tb/tb_npc_mc.sv - directed self-checking bench for npc_mc
module tb_npc_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        retire;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        halt;
    logic [1:0]  halt_cause;
    logic [31:0] a0;

    int tests = 0;
    int fails = 0;

    npc_mc #(
        .XLEN(32),
        .NR_REGS(32),
        .RESET_PC(32'h8000_0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .pc(pc),
        .inst(inst),
        .retire(retire),
        .rd(rd),
        .wdata(wdata),
        .halt(halt),
        .halt_cause(halt_cause),
        .a0(a0)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Fetch one instruction; ends with the core in EXEC.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] instr,
                         input int rdy_dly, input int rsp_dly);
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("req_addr", imem_addr, addr);
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            chk("stall_req_valid", {31'b0, imem_req_valid}, 32'h1);
            chk("stall_addr", imem_addr, addr);
            chk("stall_no_retire", {31'b0, retire}, 32'h0);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("wait_req_low", {31'b0, imem_req_valid}, 32'h0);
        for (int i = 1; i < rsp_dly; i++) begin
            step();
            chk("wait_no_retire", {31'b0, retire}, 32'h0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    task automatic exec(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                        input logic [4:0] erd, input logic [31:0] ewd, input logic [31:0] npc);
        fetch(addr, instr, 0, 1);
        chk({tag, "_retire"}, {31'b0, retire}, 32'h1);
        chk({tag, "_rd"}, {27'b0, rd}, {27'b0, erd});
        chk({tag, "_wdata"}, wdata, ewd);
        step();
        chk({tag, "_pc"}, pc, npc);
    endtask

    initial begin
        // reset values
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        step();
        step();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_inst", inst, 32'h0);
        chk("rst_retire", {31'b0, retire}, 32'h0);
        chk("rst_rd", {27'b0, rd}, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_halt", {31'b0, halt}, 32'h0);
        chk("rst_cause", {30'b0, halt_cause}, 32'h0);
        chk("rst_a0", a0, 32'h0);
        rst = 1'b0;
        step();

        // first instruction: retire three edges after reset release
        exec("addi5", 32'h8000_0000, 32'h0050_0093, 5'd1, 32'h0000_0005, 32'h8000_0004);
        chk("inst_latched", inst, 32'h0050_0093);
        exec("addi_m3", 32'h8000_0004, 32'hFFD0_0093, 5'd1, 32'hFFFF_FFFD, 32'h8000_0008);
        exec("addi7", 32'h8000_0008, 32'h0070_0113, 5'd2, 32'h0000_0007, 32'h8000_000C);
        exec("add", 32'h8000_000C, 32'h0020_81B3, 5'd3, 32'h0000_0004, 32'h8000_0010);
        exec("sub", 32'h8000_0010, 32'h4020_8233, 5'd4, 32'hFFFF_FFF6, 32'h8000_0014);
        exec("slti", 32'h8000_0014, 32'h0010_A293, 5'd5, 32'h0000_0001, 32'h8000_0018);
        exec("lui", 32'h8000_0018, 32'h1234_5337, 5'd6, 32'h1234_5000, 32'h8000_001C);
        exec("auipc", 32'h8000_001C, 32'h0000_1397, 5'd7, 32'h8000_101C, 32'h8000_0020);

        // jumps and x0 handling
        do_reset();
        exec("jal", 32'h8000_0000, 32'h0080_00EF, 5'd1, 32'h8000_0004, 32'h8000_0008);
        exec("jalr", 32'h8000_0008, 32'h0000_8067, 5'd0, 32'h8000_000C, 32'h8000_0004);
        exec("addi_x0", 32'h8000_0004, 32'h0090_0013, 5'd0, 32'h0000_0009, 32'h8000_0008);
        exec("add_x0", 32'h8000_0008, 32'h0000_0533, 5'd10, 32'h0000_0000, 32'h8000_000C);
        exec("jalr_rdrs1", 32'h8000_000C, 32'h0040_80E7, 5'd1, 32'h8000_0010, 32'h8000_0008);

        // stalled fetch: ready low 5 cycles, response 4 cycles late
        fetch(32'h8000_0008, 32'h0550_0513, 5, 4);
        chk("stall_retire", {31'b0, retire}, 32'h1);
        chk("stall_wdata", wdata, 32'h0000_0055);
        step();
        chk("stall_one_retire", {31'b0, retire}, 32'h0);
        chk("stall_pc", pc, 32'h8000_000C);
        chk("stall_a0", a0, 32'h0000_0055);
        exec("jalr_odd", 32'h8000_000C, 32'h0010_8067, 5'd0, 32'h8000_0010, 32'h8000_0010);

        // ebreak
        do_reset();
        chk("ebrk_a0", a0, 32'h0);
        fetch(32'h8000_0000, 32'h0010_0073, 0, 1);
        chk("ebrk_retire", {31'b0, retire}, 32'h1);
        chk("ebrk_rd", {27'b0, rd}, 32'h0);
        step();
        chk("ebrk_halt", {31'b0, halt}, 32'h1);
        chk("ebrk_cause", {30'b0, halt_cause}, 32'h0);
        chk("ebrk_pc", pc, 32'h8000_0000);
        chk("ebrk_no_retire", {31'b0, retire}, 32'h0);
        for (int i = 0; i < 4; i++) step();
        chk("ebrk_no_req", {31'b0, imem_req_valid}, 32'h0);
        chk("ebrk_still_halt", {31'b0, halt}, 32'h1);

        // illegal opcode after one good instruction
        do_reset();
        exec("pre_ill", 32'h8000_0000, 32'h0050_0093, 5'd1, 32'h0000_0005, 32'h8000_0004);
        fetch(32'h8000_0004, 32'h0000_0000, 0, 1);
        chk("ill_no_retire", {31'b0, retire}, 32'h0);
        step();
        chk("ill_halt", {31'b0, halt}, 32'h1);
        chk("ill_cause", {30'b0, halt_cause}, 32'h1);
        chk("ill_pc", pc, 32'h8000_0004);
        chk("ill_no_req", {31'b0, imem_req_valid}, 32'h0);

        // reset while waiting for a response; late response ignored
        do_reset();
        exec("pre_rw", 32'h8000_0000, 32'h0050_0093, 5'd1, 32'h0000_0005, 32'h8000_0004);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("rw_in_wait", {31'b0, imem_req_valid}, 32'h0);
        rst            = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0070_0113;
        step();
        chk("rw_pc", pc, 32'h8000_0000);
        chk("rw_req_low", {31'b0, imem_req_valid}, 32'h0);
        rst = 1'b0;
        step();
        chk("rw_refetch", {31'b0, imem_req_valid}, 32'h1);
        step();
        chk("rw_late_ignored", {31'b0, retire}, 32'h0);
        imem_rsp_valid = 1'b0;
        exec("rw_addi", 32'h8000_0000, 32'h0010_0093, 5'd1, 32'h0000_0001, 32'h8000_0004);

`ifdef NPC_FETCH_TIMEOUT_EN
        // watchdog: request accepted, response never arrives
        do_reset();
        imem_req_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            imem_req_ready = 1'b0;
            chk("tmo_not_yet", {31'b0, halt}, 32'h0);
        end
        step();
        chk("tmo_halt", {31'b0, halt}, 32'h1);
        chk("tmo_cause", {30'b0, halt_cause}, 32'h2);
        chk("tmo_no_retire", {31'b0, retire}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/npc_mc.md
Name: npc_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle NPC top.
- Owns PC, register file, decode and ALU in one FSM-driven block.
- Fetches instructions over a valid/ready request plus valid response memory port, instead of a hard-wired instruction.
- Retires one instruction per fetch and halts on ebreak or an illegal opcode; the C harness observes retire/halt.

Parameters:
- XLEN, 32, datapath width; only 32 supported, assertion otherwise.
- NR_REGS, 32, register count: 32 (RV32I) or 16 (RV32E); rs/rd index >= NR_REGS is illegal.
- RESET_PC, 32'h8000_0000, PC value after reset.
- TIMEOUT_CYCLES, 256, fetch watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  fetch address (= pc), stable while req_valid.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  fetched instruction.
- pc  out  XLEN  current PC.
- inst  out  32  last fetched instruction.
- retire  out  1  one-cycle pulse per retired instruction.
- rd  out  5  destination of retiring instruction (0 if none).
- wdata  out  XLEN  value written to rd on retire.
- halt  out  1  core stopped.
- halt_cause  out  2  0 ebreak, 1 illegal, 2 fetch timeout.
- a0  out  XLEN  x10, for the harness good/bad trap check.

Behaviour:
- Reset: state=RESET, pc=RESET_PC, regfile all 0, inst=0, retire=0, rd=0, wdata=0, halt=0, halt_cause=0, imem_req_valid=0. Reset mid-operation aborts any outstanding fetch; late responses are ignored until the next request.
- States:
  - RESET: 1 cycle, then FETCH.
  - FETCH: req_valid=1. On req_valid&&req_ready, go to WAIT.
  - WAIT: req_valid=0. On rsp_valid, latch inst, go to EXEC.
  - EXEC: decode, read rs1/rs2, compute, write rd, update pc, pulse retire; go to FETCH, or HALT for ebreak/illegal.
  - HALT: absorbing until rst; req_valid=0.
- rsp_valid is ignored outside WAIT. A response in the same cycle as request acceptance is not legal memory behaviour.
- Minimum latency: 3 cycles per instruction (FETCH accept, WAIT rsp, EXEC). Stalls extend FETCH/WAIT indefinitely without the optional feature.
- Supported instructions: addi, add, sub, slti, lui, auipc, jal, jalr, ebreak. Anything else is illegal.
- Immediates are sign-extended per I/U/J format. Arithmetic wraps modulo 2^XLEN. slti compares signed.
- x0 reads 0 and writes are discarded. The retire output rd still reports the encoded rd, with wdata the computed value.
- jal/jalr write pc+4 to rd. jalr target = (rs1+imm) & ~1. Targets with bit1 set are not checked.
- The PC update and the rd write occur on the same EXEC edge. jalr with rd==rs1 uses the old rs1.
- ebreak: retire=1 with rd=0, halt=1 and halt_cause=0 on the next cycle; pc stays at the ebreak address.
- Illegal: retire=0, halt=1, halt_cause=1, pc stays at the offending address.

Optional Feature:
- NPC_FETCH_TIMEOUT_EN defined: a counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entering FETCH and increments each cycle in FETCH or WAIT. Reaching TIMEOUT_CYCLES forces HALT with halt_cause=2, no retire.
- Not defined: no counter; halt_cause value 2 is never produced.

Test Plan:
- Reset then addi x1,x0,5 (00500093) with ready=1 and rsp after 1 cycle -> req at 8000_0000; retire 3 cycles after reset release; rd=1, wdata=5; pc=8000_0004.
- Program addi x1,x0,-3; addi x2,x0,7; add x3,x1,x2; sub x4,x1,x2 -> wdata 0xFFFF_FFFD, 7, 4, 0xFFFF_FFF6.
- jal x1,+8 at 8000_0000, then jalr x0,0(x1) -> pc 8000_0008 with x1=8000_0004, then pc 8000_0004; addi x0,x0,9 -> x0 reads 0.
- req_ready low 5 cycles, rsp delayed 4 -> req_valid held with addr stable; exactly one retire; no retire while stalled.
- ebreak (00100073) with a0=0 -> one retire, halt=1, cause 0, no further req; opcode 0 -> halt cause 1, no retire; rst high in WAIT -> pc=8000_0000, fetch restarts.
- NPC_FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=16 and rsp never sent -> halt=1, cause 2, 16 cycles after entering FETCH.
